multi_ch_fault_monitor: RTL and testbench
=========================================

MULTI_CH_FAULT_MONITOR -- requirements
Module: multi_ch_fault_monitor

Interface
REQ-001 SHALL have parameter NCH, default 4: number of monitored supply channels, 1..16.
REQ-002 SHALL have parameter DW, default 16: unsigned sample width for voltage and current, in mV or mA.
REQ-003 SHALL have parameter WARN_CYC, default 3: consecutive abnormal valid samples required for FAULT, 1..255.
REQ-004 SHALL have port clk, input, 1: clock; all state changes on the rising edge.
REQ-005 SHALL have port rstn, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port sample_valid, input, 1: a new sample set is present on volt/curr this cycle.
REQ-007 SHALL have port volt, input, NCH*DW: per-channel voltage; channel k occupies bits [k*DW +: DW].
REQ-008 SHALL have port curr, input, NCH*DW: per-channel current, packed the same way as volt.
REQ-009 SHALL have ports v_hi, v_lo and i_hi, input, DW each: shared thresholds, sampled every cycle.
REQ-010 SHALL have port ch_enable, input, NCH: per-channel monitor enable.
REQ-011 SHALL have port clear, input, 1: synchronous clear of latched faults and shutdown.
REQ-012 SHALL have port warning, output, NCH: channel k is in WARN.
REQ-013 SHALL have port fault, output, NCH: channel k is in FAULT.
REQ-014 SHALL have port shutdown, output, 1: global latched shutdown.
REQ-015 SHALL have port fault_ch, output, 4: index of the first faulted channel.
REQ-016 SHALL have port fault_cause, output, 3*NCH: per-channel {hv, lv, hi} captured on FAULT entry.
REQ-017 SHALL have ports log_volt and log_curr, output, DW each: fault snapshot (see Configuration).

Function
REQ-018 SHALL evaluate channel k as abnormal when any of the following holds, all comparisons strict unsigned:
- volt_k > v_hi
- volt_k < v_lo
- curr_k > i_hi
REQ-019 SHALL implement a per-channel FSM with states NORMAL, WARN and FAULT, plus a per-channel 8-bit consecutive-abnormal counter.
REQ-020 SHALL update FSMs only on cycles with sample_valid=1; otherwise state and counters hold.
REQ-021 NORMAL: an abnormal sample SHALL move the channel to WARN and set the counter to 1.
REQ-022 WARN, normal sample: SHALL return the channel to NORMAL and set the counter to 0.
REQ-023 WARN, abnormal sample: SHALL increment the counter; when the new count equals WARN_CYC, the channel SHALL enter FAULT.
REQ-024 WARN_CYC=1: an abnormal sample in NORMAL SHALL go directly to FAULT.
REQ-025 FAULT SHALL latch regardless of samples or ch_enable until clear or reset.
REQ-026 ch_enable[k]=0 SHALL force channel k to NORMAL with counter 0, unless the channel is already in FAULT.
REQ-027 warning and fault SHALL be registered decodes of state: they assert in the cycle after the causing sample edge.
REQ-028 shutdown SHALL assert one cycle after any fault bit rises and SHALL stay high until clear or reset.
REQ-029 fault_ch and fault_cause SHALL be captured only on the first FAULT entry while shutdown is low.
REQ-030 If several channels enter FAULT together, fault_ch SHALL report the lowest index.
REQ-031 clear=1 SHALL have priority over every other event in that cycle:
- all channels go to NORMAL with counters 0
- shutdown, fault_ch, fault_cause and log outputs go to 0
- the same-cycle sample is discarded

Reset
REQ-032 rstn low SHALL immediately force every state to NORMAL, every counter to 0 and every output to 0.
REQ-033 rstn low mid-WARN or mid-FAULT SHALL discard all history; monitoring resumes on the first valid sample after release.

Configuration
REQ-034 With FAULT_LOG_EN defined, log_volt and log_curr SHALL capture volt and curr of the fault_ch channel from the FAULT-causing sample, under the same capture rule as fault_ch.
REQ-035 Without FAULT_LOG_EN, log_volt and log_curr SHALL be tied to 0 and the snapshot registers SHALL be absent.

Verification
Bench settings for every scenario: NCH=4, DW=16, WARN_CYC=3, v_hi=5000, v_lo=100, i_hi=2000.
REQ-036 Escalation: ch1 volt=5200 on 3 consecutive valid cycles -> warning[1]=1 after the first sample; fault[1]=1 after the third; shutdown=1 one cycle later; fault_ch=1; fault_cause[1]={1,0,0}.
REQ-037 Recovery: ch0 curr=2500 for 2 samples, then curr=1500 -> warning[0] rises then falls; fault stays 0; counter restarts at 1 on the next abnormal sample.
REQ-038 Gaps and boundaries: abnormal samples separated by sample_valid=0 gaps -> still FAULT on the 3rd valid sample; volt=5000 exactly -> never abnormal.
REQ-039 Simultaneous faults: ch2 and ch3 reach FAULT on the same sample -> fault_ch=2; with FAULT_LOG_EN, log_volt/log_curr hold ch2's values.
REQ-040 Clear during abnormal input: clear pulsed with ch1 still at volt=5200 -> all outputs 0 next cycle; WARN re-entered on the next valid sample.
REQ-041 Reset mid-WARN: rstn pulsed low during WARN -> all outputs 0 at once; disabling ch_enable[1] during WARN -> NORMAL, but a faulted channel stays in FAULT.

Source files
------------

// File: rtl/multi_ch_fault_monitor_if.sv
// Sample/threshold/status bundle for multi_ch_fault_monitor.
// master drives samples and thresholds and observes status; slave is the monitor.
interface multi_ch_fault_monitor_if #(
    parameter int NCH = 4,
    parameter int DW  = 16
);
    logic                sample_valid;
    logic [NCH*DW-1:0]   volt;
    logic [NCH*DW-1:0]   curr;
    logic [DW-1:0]       v_hi;
    logic [DW-1:0]       v_lo;
    logic [DW-1:0]       i_hi;
    logic [NCH-1:0]      ch_enable;
    logic                clear;
    logic [NCH-1:0]      warning;
    logic [NCH-1:0]      fault;
    logic                shutdown;
    logic [3:0]          fault_ch;
    logic [3*NCH-1:0]    fault_cause;
    logic [DW-1:0]       log_volt;
    logic [DW-1:0]       log_curr;

    modport master (
        output sample_valid, volt, curr, v_hi, v_lo, i_hi, ch_enable, clear,
        input  warning, fault, shutdown, fault_ch, fault_cause, log_volt, log_curr
    );
    modport slave (
        input  sample_valid, volt, curr, v_hi, v_lo, i_hi, ch_enable, clear,
        output warning, fault, shutdown, fault_ch, fault_cause, log_volt, log_curr
    );
endinterface

// File: rtl/multi_ch_fault_monitor.sv
// Per-channel NORMAL/WARN/FAULT supply monitor with latched global shutdown.
// Define FAULT_LOG_EN to keep a volt/curr snapshot of the first faulted channel.
module mcfm_channel #(
    parameter int DW       = 16,
    parameter int WARN_CYC = 3
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          sample_valid_i,
    input  logic [DW-1:0] volt_i,
    input  logic [DW-1:0] curr_i,
    input  logic [DW-1:0] v_hi_i,
    input  logic [DW-1:0] v_lo_i,
    input  logic [DW-1:0] i_hi_i,
    input  logic          en_i,
    input  logic          clear_i,
    output logic          warn_o,
    output logic          fault_o,
    output logic          enter_o,
    output logic [2:0]    cause_o
);
    typedef enum logic [1:0] {NORMAL, WARN, FAULT} state_e;

    localparam logic [7:0] WC = 8'(WARN_CYC);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       warn_q, fault_q;
    logic       hv, lv, hi, abn;

    assign hv  = volt_i > v_hi_i;
    assign lv  = volt_i < v_lo_i;
    assign hi  = curr_i > i_hi_i;
    assign abn = hv | lv | hi;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (clear_i) begin
            state_d = NORMAL;
            cnt_d   = 8'd0;
        end else if (state_q != FAULT && !en_i) begin
            state_d = NORMAL;
            cnt_d   = 8'd0;
        end else if (sample_valid_i) begin
            case (state_q)
                NORMAL: if (abn) begin
                    cnt_d   = 8'd1;
                    state_d = (WC == 8'd1) ? FAULT : WARN;
                end
                WARN: if (abn) begin
                    cnt_d   = cnt_q + 8'd1;
                    if (cnt_d == WC) state_d = FAULT;
                end else begin
                    cnt_d   = 8'd0;
                    state_d = NORMAL;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= NORMAL;
            cnt_q   <= 8'd0;
            warn_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            warn_q  <= (state_d == WARN);
            fault_q <= (state_d == FAULT);
        end
    end

    assign warn_o  = warn_q;
    assign fault_o = fault_q;
    assign enter_o = (state_d == FAULT) && (state_q != FAULT);
    assign cause_o = {hv, lv, hi};
endmodule

module multi_ch_fault_monitor #(
    parameter int NCH      = 4,
    parameter int DW       = 16,
    parameter int WARN_CYC = 3
) (
    input  logic                      clk,
    input  logic                      rstn,
    multi_ch_fault_monitor_if.slave   bus
);
    logic [NCH-1:0]      warn, fault, enter;
    logic [NCH-1:0][2:0] cause;
    logic [NCH-1:0][2:0] fault_cause_q, fault_cause_d;
    logic                shutdown_q;
    logic [3:0]          fault_ch_q, fault_ch_d;
    logic                capture;

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        mcfm_channel #(.DW(DW), .WARN_CYC(WARN_CYC)) u_ch (
            .clk            (clk),
            .rstn           (rstn),
            .sample_valid_i (bus.sample_valid),
            .volt_i         (bus.volt[k*DW +: DW]),
            .curr_i         (bus.curr[k*DW +: DW]),
            .v_hi_i         (bus.v_hi),
            .v_lo_i         (bus.v_lo),
            .i_hi_i         (bus.i_hi),
            .en_i           (bus.ch_enable[k]),
            .clear_i        (bus.clear),
            .warn_o         (warn[k]),
            .fault_o        (fault[k]),
            .enter_o        (enter[k]),
            .cause_o        (cause[k])
        );
    end

    // Only the very first fault event is recorded; later entries leave the record alone.
    assign capture = (|enter) && !shutdown_q && !(|fault);

`ifdef FAULT_LOG_EN
    logic [DW-1:0] log_volt_q, log_curr_q, sel_volt, sel_curr;
`endif

    always_comb begin
        fault_ch_d    = 4'd0;
        fault_cause_d = '0;
`ifdef FAULT_LOG_EN
        sel_volt      = '0;
        sel_curr      = '0;
`endif
        for (int k = NCH - 1; k >= 0; k--) begin
            if (enter[k]) begin
                fault_ch_d       = 4'(k);
                fault_cause_d[k] = cause[k];
`ifdef FAULT_LOG_EN
                sel_volt         = bus.volt[k*DW +: DW];
                sel_curr         = bus.curr[k*DW +: DW];
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shutdown_q    <= 1'b0;
            fault_ch_q    <= 4'd0;
            fault_cause_q <= '0;
        end else if (bus.clear) begin
            shutdown_q    <= 1'b0;
            fault_ch_q    <= 4'd0;
            fault_cause_q <= '0;
        end else begin
            shutdown_q <= shutdown_q | (|fault);
            if (capture) begin
                fault_ch_q    <= fault_ch_d;
                fault_cause_q <= fault_cause_d;
            end
        end
    end

`ifdef FAULT_LOG_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            log_volt_q <= '0;
            log_curr_q <= '0;
        end else if (bus.clear) begin
            log_volt_q <= '0;
            log_curr_q <= '0;
        end else if (capture) begin
            log_volt_q <= sel_volt;
            log_curr_q <= sel_curr;
        end
    end
    assign bus.log_volt = log_volt_q;
    assign bus.log_curr = log_curr_q;
`else
    assign bus.log_volt = '0;
    assign bus.log_curr = '0;
`endif

    assign bus.warning     = warn;
    assign bus.fault       = fault;
    assign bus.shutdown    = shutdown_q;
    assign bus.fault_ch    = fault_ch_q;
    assign bus.fault_cause = fault_cause_q;
endmodule

// File: tb/tb_multi_ch_fault_monitor.sv
// Directed bench for multi_ch_fault_monitor: NCH=4, DW=16, WARN_CYC=3.
module tb_multi_ch_fault_monitor;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    multi_ch_fault_monitor_if #(.NCH(4), .DW(16)) bus ();

    multi_ch_fault_monitor #(.NCH(4), .DW(16), .WARN_CYC(3)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int k, input int v, input int c);
        bus.volt[k*16 +: 16] = 16'(v);
        bus.curr[k*16 +: 16] = 16'(c);
    endtask

    task automatic nominal();
        for (int k = 0; k < 4; k++) set_ch(k, 3300, 1000);
        bus.sample_valid = 1'b0;
        bus.ch_enable    = 4'hF;
        bus.clear        = 1'b0;
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        nominal();
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic test_reset();
        nominal();
        bus.v_hi = 16'd5000;
        bus.v_lo = 16'd100;
        bus.i_hi = 16'd2000;
        rstn = 1'b0;
        tick();
        tick();
        n_tests++;
        if ({bus.warning, bus.fault, bus.shutdown, bus.fault_ch, bus.fault_cause,
             bus.log_volt, bus.log_curr} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: warn=%h fault=%h sd=%b ch=%h cause=%h",
                     bus.warning, bus.fault, bus.shutdown, bus.fault_ch, bus.fault_cause);
        end
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_escalation();
        nominal();
        set_ch(1, 5200, 1000);
        bus.sample_valid = 1'b1;
        tick();
        chk("esc_warn1", 16'(bus.warning), 16'h2);
        chk("esc_fault1", 16'(bus.fault), 16'h0);
        tick();
        tick();
        chk("esc_fault3", 16'(bus.fault), 16'h2);
        chk("esc_warn3", 16'(bus.warning), 16'h0);
        chk("esc_sd_not_yet", 16'(bus.shutdown), 16'h0);
        chk("esc_fault_ch", 16'(bus.fault_ch), 16'h1);
        bus.sample_valid = 1'b0;
        tick();
        chk("esc_shutdown", 16'(bus.shutdown), 16'h1);
        chk("esc_cause", 16'(bus.fault_cause), 16'h020);
        do_clear();
        chk("esc_clr_fault", 16'(bus.fault), 16'h0);
        chk("esc_clr_sd", 16'(bus.shutdown), 16'h0);
    endtask

    task automatic test_recovery();
        nominal();
        set_ch(0, 3300, 2500);
        bus.sample_valid = 1'b1;
        tick();
        tick();
        chk("rec_warn", 16'(bus.warning), 16'h1);
        set_ch(0, 3300, 1500);
        tick();
        chk("rec_warn_fall", 16'(bus.warning), 16'h0);
        chk("rec_no_fault", 16'(bus.fault), 16'h0);
        set_ch(0, 3300, 2500);
        tick();
        tick();
        chk("rec_restart_no_fault", 16'(bus.fault), 16'h0);
        chk("rec_restart_warn", 16'(bus.warning), 16'h1);
        tick();
        chk("rec_third_fault", 16'(bus.fault), 16'h1);
        do_clear();
    endtask

    task automatic test_gaps_bounds();
        nominal();
        set_ch(2, 50, 1000);
        bus.sample_valid = 1'b1;
        tick();
        bus.sample_valid = 1'b0;
        tick();
        tick();
        chk("gap_hold_warn", 16'(bus.warning), 16'h4);
        bus.sample_valid = 1'b1;
        tick();
        bus.sample_valid = 1'b0;
        tick();
        chk("gap_no_fault", 16'(bus.fault), 16'h0);
        bus.sample_valid = 1'b1;
        tick();
        bus.sample_valid = 1'b0;
        chk("gap_fault", 16'(bus.fault), 16'h4);
        tick();
        chk("gap_cause_lv", 16'(bus.fault_cause), 16'h080);
        do_clear();
        set_ch(0, 5000, 2000);
        set_ch(1, 100, 2000);
        set_ch(2, 5000, 0);
        set_ch(3, 100, 1999);
        bus.sample_valid = 1'b1;
        repeat (4) tick();
        chk("bound_warn", 16'(bus.warning), 16'h0);
        chk("bound_fault", 16'(bus.fault), 16'h0);
        nominal();
    endtask

    task automatic test_simultaneous();
        nominal();
        set_ch(2, 6000, 1000);
        set_ch(3, 3300, 2500);
        bus.sample_valid = 1'b1;
        repeat (3) tick();
        chk("sim_fault", 16'(bus.fault), 16'hC);
        chk("sim_fault_ch", 16'(bus.fault_ch), 16'h2);
        chk("sim_cause", 16'(bus.fault_cause), 16'h300);
`ifdef FAULT_LOG_EN
        chk("sim_log_volt", bus.log_volt, 16'd6000);
        chk("sim_log_curr", bus.log_curr, 16'd1000);
`else
        chk("sim_log_volt", bus.log_volt, 16'd0);
        chk("sim_log_curr", bus.log_curr, 16'd0);
`endif
        set_ch(2, 3300, 1000);
        set_ch(3, 3300, 1000);
        set_ch(0, 50, 1000);
        repeat (3) tick();
        chk("sim_later_fault", 16'(bus.fault), 16'hD);
        chk("sim_keep_ch", 16'(bus.fault_ch), 16'h2);
        chk("sim_keep_cause", 16'(bus.fault_cause), 16'h300);
        chk("sim_sd", 16'(bus.shutdown), 16'h1);
        do_clear();
    endtask

    task automatic test_clear_abnormal();
        nominal();
        set_ch(1, 5200, 1000);
        bus.sample_valid = 1'b1;
        repeat (4) tick();
        chk("clr_pre_sd", 16'(bus.shutdown), 16'h1);
        bus.clear = 1'b1;
        tick();
        chk("clr_warn", 16'(bus.warning), 16'h0);
        chk("clr_fault", 16'(bus.fault), 16'h0);
        chk("clr_sd", 16'(bus.shutdown), 16'h0);
        chk("clr_ch", 16'(bus.fault_ch), 16'h0);
        chk("clr_cause", 16'(bus.fault_cause), 16'h0);
        chk("clr_log", bus.log_volt, 16'h0);
        bus.clear = 1'b0;
        tick();
        chk("clr_rewarn", 16'(bus.warning), 16'h2);
        do_clear();
    endtask

    task automatic test_reset_mid_and_enable();
        nominal();
        set_ch(1, 5200, 1000);
        bus.sample_valid = 1'b1;
        tick();
        bus.sample_valid = 1'b0;
        chk("rst_pre_warn", 16'(bus.warning), 16'h2);
        #3;
        rstn = 1'b0;
        #1;
        chk("rst_async_warn", 16'(bus.warning), 16'h0);
        rstn = 1'b1;
        tick();
        bus.sample_valid = 1'b1;
        tick();
        chk("rst_resume_warn", 16'(bus.warning), 16'h2);
        tick();
        chk("rst_history_gone", 16'(bus.fault), 16'h0);
        bus.sample_valid = 1'b0;
        bus.ch_enable = 4'b1101;
        tick();
        chk("en_off_warn", 16'(bus.warning), 16'h0);
        bus.ch_enable = 4'hF;
        set_ch(1, 3300, 1000);
        set_ch(2, 5200, 1000);
        bus.sample_valid = 1'b1;
        repeat (3) tick();
        chk("en_fault_set", 16'(bus.fault), 16'h4);
        bus.ch_enable = 4'h0;
        tick();
        chk("en_fault_latched", 16'(bus.fault), 16'h4);
        do_clear();
    endtask

    initial begin
        test_reset();
        test_escalation();
        test_recovery();
        test_gaps_bounds();
        test_simultaneous();
        test_clear_abnormal();
        test_reset_mid_and_enable();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
